// File: rtl/ifetch_prefetch_pkg.sv
// Shared types for the prefetching instruction fetch stage: FSM states, FIFO entry layout
// and the NOP substituted for faulting fetches.
package ifetch_prefetch_pkg;

    typedef enum logic [1:0] {
        IfIdle,
        IfReq,
        IfDrain,
        IfHalt
    } if_state_e;

    localparam int unsigned EntryW = 65;
    localparam logic [31:0] IfNop  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } if_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// First-word fall-through FIFO of fetch entries with synchronous clear; head comes straight
// from the storage registers so there is no path from the bus data to the outputs.
module ifetch_fifo
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  if_entry_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic                     head_valid_o,
    output if_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   Full   = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    if_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_i && push_i && !clear_i) begin
            assert (count_q != Full || pop_i) else $error("push into full prefetch fifo");
        end
    end
`endif

    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: Wishbone classic fetch master feeding a DEPTH-entry FWFT FIFO.
// Optional bus timeout enabled by defining IFETCH_BUS_TIMEOUT_EN.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR     = 32'h8000_0000,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_instr_o,
    output logic [31:0]              out_pc_o,
    output logic                     out_fault_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     iwbm_cyc_o,
    output logic                     iwbm_stb_o,
    output logic [31:0]              iwbm_addr_o,
    input  logic                     iwbm_ack_i,
    input  logic                     iwbm_err_i,
    input  logic [31:0]              iwbm_dat_i
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    if_state_e   state_q, state_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, fault_q, fault_d;
    logic [31:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d;
    logic        push, pop, resp, timeout, head_valid;
    if_entry_t   push_entry, head;
    logic [CntW-1:0] count;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc_i[1:0];
    assign resp        = cyc_q && (iwbm_ack_i || iwbm_err_i);
    assign pop         = out_ready_i && head_valid && !redirect_i;

`ifdef IFETCH_BUS_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q;

    assign timeout = cyc_q && !resp && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else if (!cyc_q || resp || timeout) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TmoW'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IfIdle;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            fault_q    <= 1'b0;
            addr_q     <= RESET_ADDR;
            fetch_pc_q <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            fault_q    <= fault_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        fault_d    = fault_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        push_entry = '{pc: addr_q, instr: iwbm_dat_i, fault: 1'b0};

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            fault_d    = 1'b0;
            unique case (state_q)
                IfReq, IfDrain: begin
                    // An outstanding cycle must see its response before cyc may fall.
                    stb_d = 1'b0;
                    if (resp || timeout) begin
                        cyc_d   = 1'b0;
                        state_d = IfIdle;
                    end else begin
                        state_d = IfDrain;
                    end
                end
                default: state_d = IfIdle;
            endcase
        end else begin
            unique case (state_q)
                IfIdle: begin
                    if (count < Full && !fault_q) begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                        state_d = IfReq;
                    end
                end
                IfReq: begin
                    if (iwbm_err_i || timeout) begin
                        push             = 1'b1;
                        push_entry.instr = IfNop;
                        push_entry.fault = 1'b1;
                        cyc_d            = 1'b0;
                        stb_d            = 1'b0;
                        fault_d          = 1'b1;
                        state_d          = IfHalt;
                    end else if (iwbm_ack_i) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (pop || count < Full - CntW'(1)) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            state_d = IfIdle;
                        end
                    end
                end
                IfDrain: begin
                    if (resp || timeout) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = IfIdle;
                    end
                end
                IfHalt: state_d = IfHalt;
                default: state_d = IfIdle;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .clear_i      (redirect_i),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (count)
    );

    assign out_valid_o = head_valid;
    assign out_instr_o = head.instr;
    assign out_pc_o    = head.pc;
    assign out_fault_o = head.fault;
    assign count_o     = count;
    assign iwbm_cyc_o  = cyc_q;
    assign iwbm_stb_o  = stb_q;
    assign iwbm_addr_o = addr_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: directed scenarios plus a randomized run against a
// transaction-level model (expected fetch stream per redirect epoch).
module tb_ifetch_prefetch;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
    localparam int unsigned DEPTH      = 4;
`ifdef IFETCH_BUS_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 64;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o, out_pc_o;
    logic        out_fault_o;
    logic [2:0]  count_o;
    logic        iwbm_cyc_o, iwbm_stb_o;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_ack_i = 1'b0;
    logic        iwbm_err_i = 1'b0;
    logic [31:0] iwbm_dat_i = '0;

    int   n_checks = 0;
    int   n_fail = 0;
    ent_t mq[$];
    logic [31:0] m_pc;
    logic m_halt, m_drain;

    ifetch_prefetch #(
        .RESET_ADDR     (RESET_ADDR),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .out_fault_o   (out_fault_o),
        .count_o       (count_o),
        .iwbm_cyc_o    (iwbm_cyc_o),
        .iwbm_stb_o    (iwbm_stb_o),
        .iwbm_addr_o   (iwbm_addr_o),
        .iwbm_ack_i    (iwbm_ack_i),
        .iwbm_err_i    (iwbm_err_i),
        .iwbm_dat_i    (iwbm_dat_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check_eq("count", 64'(count_o), 64'(mq.size()));
        check_eq("valid", 64'(out_valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("head_pc", 64'(out_pc_o), 64'(mq[0].pc));
            check_eq("head_instr", 64'(out_instr_o), 64'(mq[0].instr));
            check_eq("head_fault", 64'(out_fault_o), 64'(mq[0].fault));
        end
        if (iwbm_stb_o && !m_drain) check_eq("req_addr", 64'(iwbm_addr_o), 64'(m_pc));
        if (m_halt) check_eq("halt_cyc", 64'(iwbm_cyc_o), 64'(0));
        if (m_drain) check_eq("drain_cyc_stb", 64'({iwbm_cyc_o, iwbm_stb_o}), 64'(2'b10));
    endtask

    // Called just after a falling edge: check, drive inputs, predict the next rising edge.
    task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy,
                        input logic ak, input logic er);
        logic a, e, resp;
        check_model();
        a    = ak & iwbm_cyc_o;
        e    = er & iwbm_cyc_o;
        resp = a | e;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        out_ready_i   = rdy;
        iwbm_ack_i    = a;
        iwbm_err_i    = e;
        iwbm_dat_i    = a ? bus_word(iwbm_addr_o) : $urandom();
        if (rd) begin
            mq.delete();
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_halt  = 1'b0;
            m_drain = iwbm_cyc_o && !resp;
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (resp) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                end else if (e) begin
                    mq.push_back('{pc: m_pc, instr: NOP, fault: 1'b1});
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{pc: m_pc, instr: bus_word(m_pc), fault: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        redirect_i = 1'b0;
        out_ready_i = 1'b0;
        iwbm_ack_i = 1'b0;
        iwbm_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        mq.delete();
        m_pc = RESET_ADDR;
        m_halt = 1'b0;
        m_drain = 1'b0;
        check_eq("rst_cyc_stb", 64'({iwbm_cyc_o, iwbm_stb_o}), 64'(0));
        check_eq("rst_count", 64'(count_o), 64'(0));
        check_eq("rst_valid", 64'(out_valid_o), 64'(0));
        rst_i = 1'b1;
    endtask

    initial begin
        int acks;
        int wt;
        int nh;
        logic cyc_seen;
        logic rd, rdy, ak, er;
        logic [31:0] tgt;

        // Back-to-back sequential fetch with zero-wait ack.
        do_reset();
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_cyc", 64'(iwbm_cyc_o), 64'(1));
            check_eq("t1_addr", 64'(iwbm_addr_o), 64'(RESET_ADDR + 32'(4 * i)));
            if (i > 0) check_eq("t1_out_pc", 64'(out_pc_o), 64'(RESET_ADDR + 32'(4 * (i - 1))));
            step(0, 0, 1, 1, 0);
        end

        // Fill with consumer stalled, then free one slot.
        do_reset();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (iwbm_cyc_o) acks++;
            step(0, 0, 0, 1, 0);
        end
        check_eq("t2_acks", 64'(acks), 64'(4));
        check_eq("t2_full_cyc_stb", 64'({iwbm_cyc_o, iwbm_stb_o}), 64'(0));
        check_eq("t2_full_count", 64'(count_o), 64'(4));
        step(0, 0, 1, 0, 0);
        check_eq("t2_pop_count", 64'(count_o), 64'(3));
        step(0, 0, 0, 0, 0);
        check_eq("t2_refill_cyc", 64'(iwbm_cyc_o), 64'(1));
        check_eq("t2_refill_addr", 64'(iwbm_addr_o), 64'(32'h8000_0010));
        step(0, 0, 0, 1, 0);
        check_eq("t2_refull_cyc", 64'(iwbm_cyc_o), 64'(0));

        // Redirect while a request is pending; late response is discarded.
        do_reset();
        step(0, 0, 1, 0, 0);
        check_eq("t3_pending", 64'(iwbm_cyc_o), 64'(1));
        step(1, 32'h0000_1002, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("t3_drain_count", 64'(count_o), 64'(0));
        step(0, 0, 1, 1, 0);
        check_eq("t3_after_count", 64'(count_o), 64'(0));
        step(0, 0, 1, 0, 0);
        check_eq("t3_new_addr", 64'(iwbm_addr_o), 64'(32'h0000_1000));

        // Bus error halts fetch until a redirect.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check_eq("t4_err_addr", 64'(iwbm_addr_o), 64'(32'h8000_0008));
        step(0, 0, 1, 0, 1);
        check_eq("t4_fault", 64'(out_fault_o), 64'(1));
        check_eq("t4_nop", 64'(out_instr_o), 64'(NOP));
        check_eq("t4_pc", 64'(out_pc_o), 64'(32'h8000_0008));
        repeat (3) step(0, 0, 0, 1, 0);
        step(1, 32'h8000_0100, 0, 0, 0);
        check_eq("t4_flushed", 64'(out_valid_o), 64'(0));
        step(0, 0, 0, 0, 0);
        check_eq("t4_resume", 64'(iwbm_addr_o), 64'(32'h8000_0100));

        // Redirect, pop and ack in the same cycle.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(1, 32'h8000_0200, 1, 1, 0);
        check_eq("t5_empty", 64'(out_valid_o), 64'(0));
        step(0, 0, 1, 0, 0);
        check_eq("t5_addr", 64'(iwbm_addr_o), 64'(32'h8000_0200));

        // Fetch address wraps at the top of the address space.
        do_reset();
        step(1, 32'hFFFF_FFF8, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check_eq("t6_wrap", 64'(iwbm_addr_o), 64'(32'h0000_0000));
        step(0, 0, 1, 1, 0);

`ifdef IFETCH_BUS_TIMEOUT_EN
        // Silent slave: cycle is abandoned after TMO cycles with a fault entry.
        do_reset();
        nh = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_seen = iwbm_cyc_o;
            step(0, 0, 0, 0, 0);
            if (cyc_seen) begin
                nh++;
                if (nh == int'(TMO)) begin
                    mq.push_back('{pc: RESET_ADDR, instr: NOP, fault: 1'b1});
                    m_halt = 1'b1;
                end
            end
        end
        check_eq("t7_cyc_cycles", 64'(nh), 64'(TMO));
        check_eq("t7_fault", 64'(out_fault_o), 64'(1));
        check_eq("t7_pc", 64'(out_pc_o), 64'(RESET_ADDR));
`endif

        // Randomized traffic against the model.
        do_reset();
        wt = 0;
        for (int n = 0; n < 3000; n++) begin
            rd  = ($urandom_range(0, 19) == 0);
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            rdy = ($urandom_range(0, 2) != 0);
            ak  = (wt >= 3) || ($urandom_range(0, 1) == 1);
            er  = ak && ($urandom_range(0, 24) == 0);
            if (er) ak = ($urandom_range(0, 1) == 1);
            if (iwbm_cyc_o && !ak && !er) wt++;
            else wt = 0;
            step(rd, tgt, rdy, ak, er);
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
